muldiv_hilo_unit: RTL

- Execute-stage multi-cycle responder for the mul/div and HI/LO control words the decoder issues.
- Covers MULT, MULTU, DIV, DIVU, MTHI, MTLO; holds the architectural HI/LO registers that MFHI/MFLO read.
- Iterative radix-2 datapath; `busy` feeds the hazard unit to stall MFHI/MFLO and further mul/div issues.

---
 rtl/muldiv_hilo_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo_unit.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO registers.
// Define MULDIV_FAST_MUL_EN to use a single-cycle multiplier for MULT/MULTU.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               is_signed;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  always_comb begin
    is_signed = ~op[0];
    sign_a    = is_signed & src_a[WIDTH-1];
    sign_b    = is_signed & src_b[WIDTH-1];
    mag_a     = sign_a ? -src_a : src_a;
    mag_b     = sign_b ? -src_b : src_b;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  // Divide:   acc = {remainder, quotient}; restoring shift-subtract.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_sub   = div_shift[WIDTH-1:0] - opb_q;
    div_next  = (div_shift >= {1'b0, opb_q}) ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                                             : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Divide by zero leaves |dividend| in the remainder, so the dividend-sign
  // correction restores the raw dividend for HI.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = div_zero_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_d       = op;
            cnt_d      = '0;
            opb_d      = op[1] ? mag_b : mag_a;
            neg_res_d  = sign_a ^ sign_b;
            neg_rem_d  = sign_a;
            div_zero_d = op[1] & (src_b == '0);
`ifdef MULDIV_FAST_MUL_EN
            state_d    = op[1] ? StRun : StFix;
            acc_d      = op[1] ? {{WIDTH{1'b0}}, mag_a} : fast_prod;
`else
            state_d    = StRun;
            acc_d      = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
`endif
          end else begin
            if (mthi) hi_d = src_a;
            if (mtlo) lo_d = src_a;
          end
        end
        StRun: begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = op_q[1] ? div_next : mul_next;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
        end
        StFix: begin
          if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
